// File: rtl/addsub_seq_ctrl.sv
// Word-serial wide add/subtract controller: one 5-bit ripple slice reused per chunk,
// LSB chunk first, with the slice carry held between chunks.

module addsub_slice5 (
  input  logic [4:0] x,
  input  logic [4:0] y,
  input  logic       cin,
  output logic [4:0] s,
  output logic       co
);
  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int unsigned i = 0; i < 5; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end
endmodule

module addsub_seq_ctrl #(
  parameter int unsigned CHUNKS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [5*CHUNKS-1:0] A,
  input  logic [5*CHUNKS-1:0] B,
  output logic                busy,
  output logic                done,
  output logic [5*CHUNKS-1:0] R,
  output logic                cout,
  output logic                ovf
);
  localparam int unsigned N  = 5 * CHUNKS;
  localparam int unsigned IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          op_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [N-1:0]  part_q;
  logic [N-1:0]  part_d;
  logic [4:0]    x;
  logic [4:0]    y;
  logic [4:0]    sum;
  logic          co;

  addsub_slice5 u_slice (
    .x   (x),
    .y   (y),
    .cin (carry_q),
    .s   (sum),
    .co  (co)
  );

  // Chunk mux/demux written as unrolled compares to keep part-selects constant.
  always_comb begin
    x      = '0;
    y      = '0;
    part_d = part_q;
    for (int unsigned i = 0; i < CHUNKS; i++) begin
      if (idx_q == IW'(i)) begin
        x                 = a_q[5*i +: 5];
        y                 = b_q[5*i +: 5] ^ {5{op_q}};
        part_d[5*i +: 5]  = sum;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      R       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            idx_q   <= '0;
            carry_q <= op;
            part_q  <= '0;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          part_q  <= part_d;
          carry_q <= co;
          if (idx_q == LAST) begin
            R     <= part_d;
            cout  <= co;
            // y[4] on the last chunk is the effective (possibly inverted) B sign bit
            ovf   <= (a_q[N-1] == y[4]) && (sum[4] != a_q[N-1]);
            state <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl (CHUNKS=4): vector table, scoreboard on done,
// plus hand sequences for mid-run start, back-to-back and mid-run reset.

module tb_addsub_seq_ctrl;
  localparam int unsigned CHUNKS = 4;
  localparam int unsigned N      = 20;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         op;
    logic [N-1:0] r;
    logic         c;
    logic         v;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] R;
  logic         cout;
  logic         ovf;

  int   tests = 0;
  int   fails = 0;
  vec_t sb[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  addsub_seq_ctrl #(.CHUNKS(CHUNKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .R     (R),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic o);
    vec_t       e;
    logic [N:0] s;
    logic       y_msb;
    s       = {1'b0, a} + {1'b0, b ^ {N{o}}} + (N+1)'(o);
    y_msb   = b[N-1] ^ o;
    e.a     = a;
    e.b     = b;
    e.op    = o;
    e.r     = s[N-1:0];
    e.c     = s[N];
    e.v     = (a[N-1] == y_msb) && (s[N-1] != a[N-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        vec_t e;
        e = sb.pop_front();
        check($sformatf("R(%h,%h,%0d)", e.a, e.b, e.op), 32'(R), 32'(e.r));
        check($sformatf("cout(%h,%h,%0d)", e.a, e.b, e.op), 32'(cout), 32'(e.c));
        check($sformatf("ovf(%h,%h,%0d)", e.a, e.b, e.op), 32'(ovf), 32'(e.v));
      end
    end
  end

  task automatic issue(input vec_t v, input bit expect_done);
    @(negedge clk);
    start = 1'b1;
    A     = v.a;
    B     = v.b;
    op    = v.op;
    if (expect_done) sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    A     = $urandom();
    B     = $urandom();
    op    = $urandom_range(1);
  endtask

  // Called at the negedge after the accepting edge; returns at the done negedge
  task automatic wait_done(input string name, input int unsigned exp_n, input int unsigned exp_busy);
    int unsigned n  = 0;
    int unsigned bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_n));
    check({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
  endtask

  initial begin
    vec_t        v1;
    vec_t        v2;
    int unsigned dcnt;
    int unsigned gap;

    vecs[0] = '{a: 20'h0001F, b: 20'h00001, op: 1'b0, r: 20'h00020, c: 1'b0, v: 1'b0};
    vecs[1] = '{a: 20'h00000, b: 20'h00001, op: 1'b1, r: 20'hFFFFF, c: 1'b0, v: 1'b0};
    vecs[2] = '{a: 20'h00005, b: 20'h00003, op: 1'b1, r: 20'h00002, c: 1'b1, v: 1'b0};
    vecs[3] = '{a: 20'h7FFFF, b: 20'h00001, op: 1'b0, r: 20'h80000, c: 1'b0, v: 1'b1};
    vecs[4] = '{a: 20'h80000, b: 20'h00001, op: 1'b1, r: 20'h7FFFF, c: 1'b1, v: 1'b1};
    vecs[5] = '{a: 20'hFFFFF, b: 20'h00001, op: 1'b0, r: 20'h00000, c: 1'b1, v: 1'b0};
    vecs[6] = '{a: 20'h12345, b: 20'h0ABCD, op: 1'b0, r: 20'h1CF12, c: 1'b0, v: 1'b0};
    vecs[7] = '{a: 20'hAAAAA, b: 20'h55555, op: 1'b0, r: 20'hFFFFF, c: 1'b0, v: 1'b0};
    vecs[8] = '{a: 20'h00003, b: 20'h00005, op: 1'b1, r: 20'hFFFFE, c: 1'b0, v: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_R", 32'(R), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i], 1'b1);
      wait_done($sformatf("vec%0d", i), CHUNKS, CHUNKS);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'(0));
      check($sformatf("vec%0d_idle_hold_R", i), 32'(R), 32'(vecs[i].r));
    end

    for (int i = 0; i < 6; i++) begin
      v1 = model(N'($urandom()), N'($urandom()), 1'($urandom_range(1)));
      issue(v1, 1'b1);
      wait_done($sformatf("rnd%0d", i), CHUNKS, CHUNKS);
    end

    // start pulsed mid-RUN must be ignored
    v1 = model(20'h00100, 20'h00200, 1'b0);
    issue(v1, 1'b1);
    start = 1'b1;
    A     = 20'hFFFFF;
    B     = 20'hFFFFF;
    op    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("midrun_start", CHUNKS - 1, CHUNKS - 1);
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrun_start_extra_done", 32'(dcnt), 32'(0));
    check("midrun_start_busy_after", 32'(busy), 32'(0));

    // back-to-back: new start on the DONE cycle
    v1 = model(20'h0F0F0, 20'h01010, 1'b1);
    v2 = model(20'h7FFFF, 20'h7FFFF, 1'b0);
    issue(v1, 1'b1);
    wait_done("b2b_first", CHUNKS, CHUNKS);
    start = 1'b1;
    A     = v2.a;
    B     = v2.b;
    op    = v2.op;
    sb.push_back(v2);
    @(negedge clk);
    start = 1'b0;
    check("b2b_rerun_busy", 32'(busy), 32'(1));
    check("b2b_rerun_done", 32'(done), 32'(0));
    check("b2b_R_held_in_run", 32'(R), 32'(v1.r));
    wait_done("b2b_second", CHUNKS, CHUNKS);
    gap = 0;
    repeat (1) gap++;
    check("b2b_done_gap", 32'(CHUNKS + gap), 32'(5));

    // reset asserted for one edge while idx=2
    @(negedge clk);
    issue(model(20'h11111, 20'h22222, 1'b0), 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_R", 32'(R), 32'(0));
    check("midrst_cout", 32'(cout), 32'(0));
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst_no_done", 32'(dcnt), 32'(0));
    v1 = model(20'h00ABC, 20'h00123, 1'b1);
    issue(v1, 1'b1);
    wait_done("post_rst", CHUNKS, CHUNKS);
    @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
